// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with a 2-bit direction counter per entry.
// Optional `BTB_STATS_EN adds resolved-branch and mispredict counters.
module btb_predictor #(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC_IF,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        stall,
    input  logic        ex_valid,
    input  logic        ex_is_br,
    input  logic [31:0] ex_PC,
    input  logic        ex_br_taken,
    input  logic [31:0] ex_br_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] fix_PC,
    output logic [31:0] br_count,
    output logic [31:0] miss_count
);
    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = 30 - IDXW;

    logic [ENTRIES-1:0]      valid;
    logic [ENTRIES-1:0][1:0] cnt;
    logic [TAGW-1:0]         tag_q    [ENTRIES];
    logic [31:0]             target_q [ENTRIES];

    logic [IDXW-1:0] rd_idx;
    logic [IDXW-1:0] wr_idx;
    logic            rd_hit;
    logic            wr_hit;
    logic            res;
    logic            upd;

    assign rd_idx = PC_IF[IDXW+1:2];
    assign wr_idx = ex_PC[IDXW+1:2];
    assign rd_hit = valid[rd_idx] && (tag_q[rd_idx] == PC_IF[31:IDXW+2]);
    assign wr_hit = valid[wr_idx] && (tag_q[wr_idx] == ex_PC[31:IDXW+2]);

    always_comb begin
        pred_taken  = 1'b0;
        pred_target = PC_IF + 32'd4;
        if (rd_hit && cnt[rd_idx][1]) begin
            pred_taken  = 1'b1;
            pred_target = target_q[rd_idx];
        end
    end

    assign res        = ex_valid && ex_is_br;
    assign upd        = res && !stall;
    assign mispredict = res && ((ex_pred_taken != ex_br_taken) ||
                                (ex_br_taken && (ex_pred_target != ex_br_target)));
    assign fix_PC     = ex_br_taken ? ex_br_target : ex_PC + 32'd4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            cnt   <= {ENTRIES{2'b01}};
        end else if (upd) begin
            if (wr_hit) begin
                if (ex_br_taken) begin
                    if (cnt[wr_idx] != 2'b11) cnt[wr_idx] <= cnt[wr_idx] + 2'd1;
                end else begin
                    if (cnt[wr_idx] != 2'b00) cnt[wr_idx] <= cnt[wr_idx] - 2'd1;
                end
            end else if (ex_br_taken) begin
                valid[wr_idx] <= 1'b1;
                cnt[wr_idx]   <= 2'b10;
            end
        end
    end

    // Tag/target need no reset: they are only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (!rst && upd && ex_br_taken) begin
            target_q[wr_idx] <= ex_br_target;
            if (!wr_hit) tag_q[wr_idx] <= ex_PC[31:IDXW+2];
        end
    end

`ifdef BTB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count   <= '0;
            miss_count <= '0;
        end else if (upd) begin
            br_count <= br_count + 32'd1;
            if (mispredict) miss_count <= miss_count + 32'd1;
        end
    end
`else
    assign br_count   = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Randomized self-checking bench for btb_predictor (ENTRIES=16) against an
// array-based reference model of the branch target buffer.
module tb_btb_predictor;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC_IF;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        stall;
    logic        ex_valid;
    logic        ex_is_br;
    logic [31:0] ex_PC;
    logic        ex_br_taken;
    logic [31:0] ex_br_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] fix_PC;
    logic [31:0] br_count;
    logic [31:0] miss_count;

    int n_checks = 0;
    int n_fail   = 0;

    btb_predictor #(.ENTRIES(16)) dut (
        .clk(clk), .rst(rst), .PC_IF(PC_IF),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .stall(stall), .ex_valid(ex_valid), .ex_is_br(ex_is_br), .ex_PC(ex_PC),
        .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .mispredict(mispredict), .fix_PC(fix_PC),
        .br_count(br_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // Reference model: each slot remembers which branch owns it (its whole
    // word address) plus the learned target and confidence level 0..3.
    bit          m_valid [16];
    int unsigned m_owner [16];
    int unsigned m_tgt   [16];
    int          m_conf  [16];
    int unsigned m_br    = 0;
    int unsigned m_miss  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned slot_of(input int unsigned pc);
        return (pc / 4) % 16;
    endfunction

    function automatic bit owns(input int unsigned pc);
        int unsigned s = slot_of(pc);
        return m_valid[s] && (m_owner[s] / 16 == (pc / 4) / 16);
    endfunction

    function automatic bit model_taken(input int unsigned pc);
        return owns(pc) && (m_conf[slot_of(pc)] >= 2);
    endfunction

    function automatic int unsigned model_target(input int unsigned pc);
        return model_taken(pc) ? m_tgt[slot_of(pc)] : pc + 4;
    endfunction

    function automatic bit model_miss();
        if (!(ex_valid && ex_is_br)) return 0;
        if (ex_pred_taken != ex_br_taken) return 1;
        return ex_br_taken && (ex_pred_target != ex_br_target);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0;
            m_conf[i]  = 1;
        end
        m_br   = 0;
        m_miss = 0;
    endtask

    task automatic model_update(input bit was_miss);
        int unsigned s = slot_of(ex_PC);
        if (!(ex_valid && ex_is_br) || stall) return;
        m_br++;
        if (was_miss) m_miss++;
        if (owns(ex_PC)) begin
            if (ex_br_taken) begin
                m_conf[s] = (m_conf[s] == 3) ? 3 : m_conf[s] + 1;
                m_tgt[s]  = ex_br_target;
            end else begin
                m_conf[s] = (m_conf[s] == 0) ? 0 : m_conf[s] - 1;
            end
        end else if (ex_br_taken) begin
            m_valid[s] = 1;
            m_owner[s] = ex_PC / 4;
            m_tgt[s]   = ex_br_target;
            m_conf[s]  = 2;
        end
    endtask

    task automatic check_stats();
`ifdef BTB_STATS_EN
        check("br_count", br_count, m_br);
        check("miss_count", miss_count, m_miss);
`else
        check("br_count", br_count, 32'd0);
        check("miss_count", miss_count, 32'd0);
`endif
    endtask

    // One cycle: drive just after a rising edge, check at the falling edge,
    // then let the edge commit and advance the model.
    task automatic cycle(input logic [31:0] pc, input bit v, input bit br,
                         input logic [31:0] epc, input bit tk, input logic [31:0] tgt,
                         input bit ptk, input logic [31:0] ptgt, input bit st);
        bit miss;
        PC_IF = pc; ex_valid = v; ex_is_br = br; ex_PC = epc;
        ex_br_taken = tk; ex_br_target = tgt;
        ex_pred_taken = ptk; ex_pred_target = ptgt; stall = st;
        @(negedge clk);
        miss = model_miss();
        check("pred_taken", {31'd0, pred_taken}, {31'd0, model_taken(pc)});
        check("pred_target", pred_target, model_target(pc));
        check("mispredict", {31'd0, mispredict}, {31'd0, miss});
        check("fix_PC", fix_PC, tk ? tgt : epc + 32'd4);
        check_stats();
        @(posedge clk);
        model_update(miss);
        #1;
    endtask

    task automatic idle_lookup(input logic [31:0] pc);
        cycle(pc, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    endtask

    task automatic resolve(input logic [31:0] epc, input bit tk, input logic [31:0] tgt,
                           input bit ptk, input logic [31:0] ptgt, input bit st);
        cycle(epc, 1, 1, epc, tk, tgt, ptk, ptgt, st);
    endtask

    task automatic expect_lookup(input string tag, input logic [31:0] pc,
                                 input bit tk, input logic [31:0] tgt);
        PC_IF = pc; ex_valid = 0; ex_is_br = 0; stall = 0;
        #1;
        check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, tk});
        check({tag, "_target"}, pred_target, tgt);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] base;
        case ($urandom_range(0, 3))
            0: base = 32'h0000_0000;
            1: base = 32'h0000_0040;
            2: base = 32'h0000_1000;
            default: base = 32'hFFFF_FFC0;
        endcase
        return base + 32'($urandom_range(0, 15)) * 4;
    endfunction

    initial begin
        logic [31:0] epc, tgt, ptgt;
        bit ptk;
        rst = 1'b1; PC_IF = 32'h100; stall = 0; ex_valid = 0; ex_is_br = 0;
        ex_PC = 0; ex_br_taken = 0; ex_br_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
        model_reset();
        #1;
        check("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        check("rst_pred_target", pred_target, 32'h104);
        check("rst_br_count", br_count, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        expect_lookup("cold", 32'h100, 0, 32'h104);
        resolve(32'h100, 1, 32'h80, 0, 32'h104, 0);
        expect_lookup("first_taken", 32'h100, 1, 32'h80);
        resolve(32'h100, 0, 32'h80, 1, 32'h80, 0);
        expect_lookup("dir_flip", 32'h100, 0, 32'h104);
        resolve(32'h100, 1, 32'h80, 0, 32'h104, 0);
        resolve(32'h100, 1, 32'h90, 1, 32'h80, 0);
        expect_lookup("tgt_change", 32'h100, 1, 32'h90);
        resolve(32'h100, 0, 32'h90, 1, 32'h90, 0);
        expect_lookup("cnt_was_3", 32'h100, 1, 32'h90);
        resolve(32'h140, 1, 32'h200, 0, 32'h144, 0);
        expect_lookup("alias_new", 32'h140, 1, 32'h200);
        expect_lookup("alias_old", 32'h100, 0, 32'h104);
        resolve(32'h100, 1, 32'h80, 0, 32'h104, 1);
        expect_lookup("stall_nochg", 32'h100, 0, 32'h104);
        idle_lookup(32'hFFFF_FFFC);
        expect_lookup("wrap", 32'hFFFF_FFFC, 0, 32'h0);
        cycle(32'h140, 1, 0, 32'h140, 0, 32'h0, 1, 32'h200, 0);
        expect_lookup("jal_nochg", 32'h140, 1, 32'h200);

        for (int i = 0; i < 500; i++) begin
            epc = rand_pc();
            tgt = rand_pc();
            if ($urandom_range(0, 1) == 0) begin
                ptk  = model_taken(epc);
                ptgt = model_target(epc);
            end else begin
                ptk  = 1'($urandom_range(0, 1));
                ptgt = ($urandom_range(0, 1) == 0) ? tgt : rand_pc();
            end
            cycle(rand_pc(), $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 70,
                  epc, 1'($urandom_range(0, 1)), tgt, ptk, ptgt, $urandom_range(0, 99) < 20);
        end

        // Reset mid-cycle while an update is pending: the update must be lost.
        resolve(32'h100, 1, 32'h80, 0, 32'h104, 0);
        resolve(32'h100, 1, 32'h80, 1, 32'h80, 0);
        PC_IF = 32'h100; ex_valid = 1; ex_is_br = 1; ex_PC = 32'h100;
        ex_br_taken = 1; ex_br_target = 32'h80; ex_pred_taken = 0; stall = 0;
        #2 rst = 1'b1;
        #1;
        check("midrst_pred_taken", {31'd0, pred_taken}, 32'd0);
        check("midrst_pred_target", pred_target, 32'h104);
        check("midrst_br_count", br_count, 32'd0);
        check("midrst_mispredict", {31'd0, mispredict}, 32'd1);
        check("midrst_fix_PC", fix_PC, 32'h80);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        expect_lookup("post_rst", 32'h100, 0, 32'h104);
        idle_lookup(32'h100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/btb_predictor.md
# btb_predictor

Branch target buffer and direction predictor for the RV32I pipeline. It sits beside the next-PC selection logic. At IF it predicts taken/not-taken and a target for the current fetch PC. At EX it compares the resolved branch against the prediction carried down the pipeline, raises a mispredict redirect with the correct PC, and trains its table. The core uses `pred_target` as the default next PC, and `fix_PC` overrides it when `mispredict` is high.

## Interface
- `ENTRIES`, 16: number of direct-mapped entries; power of two, 4..256.
- `IDXW`, log2(ENTRIES): index width; derived, not overridden.

- `clk` in 1: core clock, rising edge.
- `rst` in 1: one clock; reset is asynchronous and active-high.
- `PC_IF` in 32: current fetch PC (word aligned).
- `pred_taken` out 1: prediction for `PC_IF`.
- `pred_target` out 32: predicted next PC for `PC_IF`.
- `stall` in 1: EX stage held this cycle; suppresses update and statistics.
- `ex_valid` in 1: EX holds a real (non-bubble) instruction.
- `ex_is_br` in 1: EX instruction is a conditional branch.
- `ex_PC` in 32: PC of the EX instruction.
- `ex_br_taken` in 1: resolved direction.
- `ex_br_target` in 32: resolved taken target.
- `ex_pred_taken` in 1: `pred_taken` captured at IF for this instruction.
- `ex_pred_target` in 32: `pred_target` captured at IF for this instruction.
- `mispredict` out 1: redirect required; the core flushes IF/ID.
- `fix_PC` out 32: correct next PC when `mispredict`=1.
- `br_count` out 32: resolved branches counted; present only with the statistics option.
- `miss_count` out 32: mispredicts counted; present only with the statistics option.

## Operation
- Entry fields: `valid`, `tag` = PC[31:IDXW+2], `target`[31:0], `cnt`[1:0] (2-bit saturating counter).
- Index = PC[IDXW+1:2].
- Lookup is combinational on `PC_IF`.
  - hit = `valid` && tag match.
  - If hit && `cnt`[1]: `pred_taken`=1, `pred_target`=`target`.
  - Otherwise: `pred_taken`=0, `pred_target`=`PC_IF`+4.
- Resolution condition: `res` = `ex_valid` && `ex_is_br`.
- `mispredict` = `res` && (`ex_pred_taken` != `ex_br_taken` || (`ex_br_taken` && `ex_pred_target` != `ex_br_target`)).
  - It is combinational and is not gated by `stall`. The core must not act on it while stalled.
- `fix_PC` = `ex_br_taken` ? `ex_br_target` : `ex_PC`+4, independent of `mispredict`.
- Update happens at the clock edge when `res` && !`stall`, indexed by `ex_PC`.
  - Tag hit, taken: `cnt` = min(`cnt`+1, 3) and `target` = `ex_br_target`.
  - Tag hit, not taken: `cnt` = max(`cnt`-1, 0); `target` is unchanged.
  - Tag miss, taken: allocate, overwriting any entry at that index. Set `valid`=1, `tag`, `target`=`ex_br_target`, `cnt`=2'b10.
  - Tag miss, not taken: no change.
- All PC arithmetic is 32-bit and wraps modulo 2^32 (0xFFFFFFFC+4 = 0).
- Non-branch EX instructions (jal/jalr) never touch the table or the counters.

## Timing
- Lookup has zero latency: outputs follow `PC_IF` in the same cycle.
- An update becomes visible to lookup the cycle after its edge.
- Simultaneous lookup and update of the same index: lookup returns the pre-update contents. There is no bypass.
- `mispredict` and `fix_PC` have zero latency from the EX inputs.
- Reset, asynchronous, any time including mid-update:
  - all `valid`=0 and all `cnt`=2'b01;
  - `br_count` and `miss_count` = 0;
  - the table update in that cycle is lost.
- Outputs during reset:
  - `pred_taken`=0 and `pred_target`=`PC_IF`+4.
  - `mispredict` and `fix_PC` follow the EX inputs combinationally.

## Configuration
- `BTB_STATS_EN` defined:
  - `br_count` increments on each `res` && !`stall` edge.
  - `miss_count` increments on each `mispredict` && !`stall` edge.
  - Both are 32-bit and wrap.
- Not defined: both outputs are tied to 0, no counter registers exist, and the port list is unchanged.

## Test plan
All scenarios use ENTRIES=16.
- Cold lookup: after reset, `PC_IF`=0x100 -> `pred_taken`=0, `pred_target`=0x104.
- First taken branch: `ex_PC`=0x100, `ex_br_taken`=1, target 0x80, `ex_pred_taken`=0.
  - That cycle: `mispredict`=1, `fix_PC`=0x80.
  - Next cycle, `PC_IF`=0x100 -> `pred_taken`=1, `pred_target`=0x80.
  - `miss_count`=1, `br_count`=1.
- Direction flip: continue from the previous scenario. Resolve 0x100 not-taken with `ex_pred_taken`=1, target 0x80.
  - That cycle: `mispredict`=1, `fix_PC`=0x104.
  - `cnt` goes 10 -> 01; next lookup of 0x100 gives `pred_taken`=0.
- Target change: entry 0x100 with `cnt`=10. Resolve taken to 0x90 with predicted taken to 0x80.
  - `mispredict`=1, `fix_PC`=0x90.
  - Next lookup of 0x100: `pred_target`=0x90; `cnt`=11.
- Alias eviction: with 0x100 trained taken, resolve 0x140 (same index 0) taken to 0x200.
  - Lookup 0x140 -> taken to 0x200.
  - Lookup 0x100 -> `pred_taken`=0, `pred_target`=0x104.
- Stall and reset: resolve 0x100 taken with `stall`=1.
  - No table change and counters unchanged; `mispredict` is still 1.
  - Then assert `rst` mid-cycle after training -> lookup 0x100 immediately gives `pred_taken`=0, and `br_count`=0.
